cs_measure_engine: RTL and testbench

Reader/consumer of the sparse sensing-matrix index ROM (M rows × K column indices per row, plus signal length N stored at word M*K). On start it walks the ROM, fetches each indexed sample from the signal sample buffer and sums K samples per row. It emits M compressed measurements y[r] = Σ x[idx(r,k)]. It sits between the sample buffer and the measurement output FIFO/UART in the compressed-sensing datapath.

---
 rtl/cs_measure_engine.sv | 212 +++++++++++++++++++++
 tb/tb_cs_measure_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cs_measure_engine.sv
// ---------------------------------------------------------------------------
// cs_measure_engine
//
// Produces the compressed-sensing measurements y[r] = sum_k x[idx(r,k)].
// On start it reads the signal length N from the top of the sparse index ROM
// and then walks the M*K column indices. Each index is used to fetch a sample
// from the sample buffer, and the K samples of every row are summed. The ROM
// read, the sample read and the accumulate are pipelined, so one index is
// retired per clock once the pipe has filled.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle run request, only honoured while idle
//   busy       out  high from the cycle after start is accepted until done
//   done       out  one-cycle pulse together with the last meas_valid
//   rom_addr   out  index-ROM address (registered)
//   rom_q      in   index-ROM data, one cycle after rom_addr
//   smp_addr   out  sample-buffer address (registered)
//   smp_q      in   sample data, one cycle after smp_addr
//   meas_valid out  one-cycle strobe per finished row
//   meas_idx   out  row number of the current measurement
//   meas_data  out  signed sum of the K samples of that row
//   idx_err    out  sticky flag: an index >= N was seen during the run
// ---------------------------------------------------------------------------
module cs_measure_engine #(
  parameter int M   = 48,
  parameter int K   = 8,
  parameter int SW  = 12,
  parameter int AW  = 10,
  parameter int XAW = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [AW-1:0]               rom_addr,
  input  logic [7:0]                  rom_q,
  output logic [XAW-1:0]              smp_addr,
  input  logic [SW-1:0]               smp_q,
  output logic                        meas_valid,
  output logic [$clog2(M)-1:0]        meas_idx,
  output logic [SW+$clog2(K)-1:0]     meas_data,
  output logic                        idx_err
);

  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int RW    = $clog2(M);
  localparam int MDW   = SW + $clog2(K);
  localparam int TOTAL = M * K;
  localparam int JW    = $clog2(TOTAL + 1);

  localparam logic [AW-1:0] HDR_ADDR = AW'(TOTAL);
  localparam logic [JW-1:0] J_TOTAL  = JW'(TOTAL);
  localparam logic [KW-1:0] K_LAST   = KW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t r_state;
  state_t w_nextState;

  logic            w_accept;
  logic            w_fetch;
  logic            w_lastAcc;

  logic [JW-1:0]   r_fetchIdx;
  logic            r_hdrIssued;
  logic            r_hdrQValid;
  logic            r_romValid;
  logic            r_romQValid;
  logic            r_smpValid;
  logic            r_inRange1;
  logic            r_sampleValid;
  logic            r_inRange2;
  logic [7:0]      r_nLen;
  logic [KW-1:0]   r_kCnt;
  logic [RW-1:0]   r_rowCnt;
  logic signed [MDW-1:0] r_acc;

  logic signed [MDW-1:0] w_term;
  logic signed [MDW-1:0] w_sum;

  // Out-of-range indices still flow through the pipe but contribute zero,
  // so the row timing never depends on the data.
  assign w_term = r_inRange2 ? {{(MDW-SW){smp_q[SW-1]}}, smp_q} : '0;
  assign w_sum  = (r_kCnt == '0) ? w_term : r_acc + w_term;

  // The run ends on the accumulate of the very last index of the last row.
  assign w_lastAcc = r_sampleValid && (r_kCnt == K_LAST) && (r_rowCnt == ROW_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: there is no wait state, the pipeline drains inside RUN.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start)     w_nextState = S_RUN;
      S_RUN:   if (w_lastAcc) w_nextState = S_IDLE;
      default:                w_nextState = S_IDLE;
    endcase
  end

  // FSM decodes: start is only taken in IDLE, index fetches only run in RUN.
  always_comb begin
    w_accept = 1'b0;
    w_fetch  = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = start;
      S_RUN:   w_fetch  = (r_fetchIdx < J_TOTAL);
      default: ;
    endcase
  end

  // Datapath. Each pipeline stage carries a valid bit:
  //   fetch (rom_addr)  -> ROM data valid -> smp_addr + range check
  //   -> sample data valid -> accumulate.
  // The header word (N) follows the same one-cycle ROM latency on its own
  // flag, which lands it in r_nLen one cycle before the first range check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      rom_addr      <= '0;
      smp_addr      <= '0;
      meas_valid    <= 1'b0;
      meas_idx      <= '0;
      meas_data     <= '0;
      idx_err       <= 1'b0;
      r_fetchIdx    <= '0;
      r_hdrIssued   <= 1'b0;
      r_hdrQValid   <= 1'b0;
      r_romValid    <= 1'b0;
      r_romQValid   <= 1'b0;
      r_smpValid    <= 1'b0;
      r_inRange1    <= 1'b0;
      r_sampleValid <= 1'b0;
      r_inRange2    <= 1'b0;
      r_nLen        <= '0;
      r_kCnt        <= '0;
      r_rowCnt      <= '0;
      r_acc         <= '0;
    end else begin
      meas_valid    <= 1'b0;
      done          <= 1'b0;
      r_hdrIssued   <= 1'b0;
      r_hdrQValid   <= r_hdrIssued;
      r_romQValid   <= r_romValid;
      r_sampleValid <= r_smpValid;
      r_inRange2    <= r_inRange1;

      if (w_accept) begin
        rom_addr    <= HDR_ADDR;
        busy        <= 1'b1;
        idx_err     <= 1'b0;
        r_fetchIdx  <= '0;
        r_hdrIssued <= 1'b1;
        r_romValid  <= 1'b0;
        r_kCnt      <= '0;
        r_rowCnt    <= '0;
      end else if (w_fetch) begin
        rom_addr   <= AW'(r_fetchIdx);
        r_fetchIdx <= r_fetchIdx + JW'(1);
        r_romValid <= 1'b1;
      end else begin
        r_romValid <= 1'b0;
      end

      if (r_hdrQValid) begin
        r_nLen <= rom_q;
      end

      if (r_romQValid) begin
        smp_addr   <= rom_q[XAW-1:0];
        r_inRange1 <= (rom_q < r_nLen);
        r_smpValid <= 1'b1;
      end else begin
        r_smpValid <= 1'b0;
      end

      if (r_sampleValid) begin
        r_acc <= w_sum;
        if (!r_inRange2) begin
          idx_err <= 1'b1;
        end
        if (r_kCnt == K_LAST) begin
          r_kCnt     <= '0;
          r_rowCnt   <= r_rowCnt + RW'(1);
          meas_valid <= 1'b1;
          meas_idx   <= r_rowCnt;
          meas_data  <= w_sum;
        end else begin
          r_kCnt <= r_kCnt + KW'(1);
        end
      end

      if (w_lastAcc) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cs_measure_engine.sv
// ---------------------------------------------------------------------------
// tb_cs_measure_engine
//
// Drives cs_measure_engine with a modelled index ROM and sample buffer (both
// one-cycle registered reads). The expected measurements, strobe timing,
// address sequence and error flag are worked out from the ROM/buffer
// contents with plain loops and cycle arithmetic relative to the edge that
// accepts start, and compared with the DUT on every falling edge of a run.
// ---------------------------------------------------------------------------
module tb_cs_measure_engine;

  localparam int M        = 48;
  localparam int K        = 8;
  localparam int SW       = 12;
  localparam int AW       = 10;
  localparam int XAW      = 7;
  localparam int TOTAL    = M * K;
  localparam int LAST_CYC = 4 + M * K;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [AW-1:0]     rom_addr;
  logic [7:0]        rom_q = '0;
  logic [XAW-1:0]    smp_addr;
  logic [SW-1:0]     smp_q = '0;
  logic              meas_valid;
  logic [5:0]        meas_idx;
  logic [SW+2:0]     meas_data;
  logic              idx_err;

  logic [7:0]        romMem [0:1023];
  logic [SW-1:0]     xMem   [0:127];

  int expMeas [M];
  int firstBad;
  int assertCount = 0;
  int failCount   = 0;

  cs_measure_engine #(.M(M), .K(K), .SW(SW), .AW(AW), .XAW(XAW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .smp_addr   (smp_addr),
    .smp_q      (smp_q),
    .meas_valid (meas_valid),
    .meas_idx   (meas_idx),
    .meas_data  (meas_data),
    .idx_err    (idx_err)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Registered ROM and sample buffer, one cycle of read latency each.
  always @(posedge clk) begin
    rom_q <= romMem[rom_addr];
    smp_q <= xMem[smp_addr];
  end

  // Single comparison point; every check in the bench funnels through here.
  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: y[r] is the sum of the in-range samples of row r; the first
  // out-of-range index position decides when the error flag must rise.
  function automatic void computeModel();
    int nLen;
    int idx;
    int sum;
    nLen     = int'(romMem[TOTAL]);
    firstBad = -1;
    for (int r = 0; r < M; r++) begin
      sum = 0;
      for (int k = 0; k < K; k++) begin
        idx = int'(romMem[r*K + k]);
        if (idx < nLen) begin
          sum += int'($signed(xMem[idx % 128]));
        end else if (firstBad < 0) begin
          firstBad = r*K + k;
        end
      end
      expMeas[r] = sum;
    end
  endfunction

  // Expected outputs c edges after the edge that accepted start.
  task automatic checkCycle(input int c);
    bit expValid;
    int r;
    int expAddr;
    expValid = (c >= 12) && (c <= LAST_CYC) && (((c - 4) % 8) == 0);
    r        = (c - 4) / 8 - 1;
    checkOutput($sformatf("meas_valid c%0d", c), meas_valid, expValid);
    if (expValid) begin
      checkOutput($sformatf("meas_idx r%0d", r), meas_idx, r);
      checkOutput($sformatf("meas_data r%0d", r), $signed(meas_data), expMeas[r]);
    end
    checkOutput($sformatf("done c%0d", c), done, (c == LAST_CYC));
    checkOutput($sformatf("busy c%0d", c), busy, (c < LAST_CYC));
    checkOutput($sformatf("idx_err c%0d", c), idx_err, (firstBad >= 0) && (c >= 5 + firstBad));
    expAddr = (c == 0) ? TOTAL : ((c <= TOTAL) ? c - 1 : TOTAL - 1);
    checkOutput($sformatf("rom_addr c%0d", c), rom_addr, expAddr);
    if (c >= 3 && c <= TOTAL + 2) begin
      checkOutput($sformatf("smp_addr c%0d", c), smp_addr, int'(romMem[c-3]) % 128);
    end
  endtask

  // Starts a run (caller is at a falling edge), optionally re-pulses start
  // so that edge number extraStartAt samples it, and checks through lastCycle.
  task automatic applyStimulus(input int extraStartAt, input int lastCycle);
    computeModel();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkCycle(0);
    for (int c = 1; c <= lastCycle; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkCycle(c);
      start = (c + 1 == extraStartAt);
    end
    start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " meas_valid"}, meas_valid, 0);
    checkOutput({tag, " idx_err"}, idx_err, 0);
    checkOutput({tag, " rom_addr"}, rom_addr, 0);
    checkOutput({tag, " smp_addr"}, smp_addr, 0);
    checkOutput({tag, " meas_idx"}, meas_idx, 0);
    checkOutput({tag, " meas_data"}, meas_data, 0);
  endtask

  // Production-style table: fixed row 0, random in-range rows, N = 96.
  task automatic loadProduction();
    int rowZero [8] = '{2, 4, 26, 29, 47, 50, 67, 81};
    for (int i = 0; i < 1024; i++) romMem[i] = '0;
    for (int j = 0; j < TOTAL; j++) romMem[j] = 8'($urandom_range(0, 95));
    for (int k = 0; k < 8; k++) romMem[k] = 8'(rowZero[k]);
    romMem[TOTAL] = 8'd96;
  endtask

  task automatic loadRamp();
    for (int i = 0; i < 128; i++) xMem[i] = SW'(i);
  endtask

  initial begin
    int nLen;
    loadProduction();
    loadRamp();

    // Reset state.
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Production table, ramp samples.
    computeModel();
    checkOutput("model row0 ramp", expMeas[0], 306);
    applyStimulus(0, LAST_CYC + 4);

    // All samples -1.
    for (int i = 0; i < 128; i++) xMem[i] = 12'hFFF;
    computeModel();
    checkOutput("model all -1", expMeas[10], -8);
    applyStimulus(0, LAST_CYC + 4);

    // One out-of-range index in row 0.
    loadRamp();
    romMem[5] = 8'd100;
    computeModel();
    checkOutput("model row0 bad idx", expMeas[0], 256);
    applyStimulus(0, LAST_CYC + 4);

    // Restart clears idx_err; start while busy ignored; back-to-back start.
    romMem[5] = 8'd50;
    applyStimulus(100, LAST_CYC);
    applyStimulus(0, LAST_CYC + 4);

    // Randomized tables and samples, including indices at and above N.
    for (int it = 0; it < 2; it++) begin
      nLen = $urandom_range(1, 128);
      for (int j = 0; j < TOTAL; j++) romMem[j] = 8'($urandom_range(0, nLen + 15));
      romMem[TOTAL] = 8'(nLen);
      romMem[0] = 8'(nLen - 1);
      romMem[1] = 8'd0;
      for (int i = 0; i < 128; i++) xMem[i] = SW'($urandom);
      applyStimulus(0, LAST_CYC + 4);
    end

    // Asynchronous reset in the middle of a run.
    loadProduction();
    loadRamp();
    applyStimulus(0, 50);
    rst_n = 1'b0;
    #1;
    checkAllZero("midrun reset");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("no strobe in reset", meas_valid, 0);
      checkOutput("no done in reset", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, LAST_CYC + 4);

    // N = 0: every index is out of range.
    romMem[TOTAL] = 8'd0;
    computeModel();
    checkOutput("model N0 row0", expMeas[0], 0);
    applyStimulus(0, LAST_CYC + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
